// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// the bubble and halt encodings, and the sequential PC step.
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam int unsigned PC_INC            = 4;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Bundle of program-load, fetch-control and IF/ID latch signals.
// There is no valid/ready handshake here: control inputs are sampled on
// every rising edge, and o_valid marks a latch slot that holds a real
// instruction (a bubble has o_valid=0 and a NOP word). o_state exposes the
// fetch FSM for observation.
interface if_fetch_stage_if #(
    parameter int NB_ADDR   = 32,
    parameter int NB_INST   = 32,
    parameter int MEM_DEPTH = 64
) ();
    import if_fetch_stage_pkg::*;

    localparam int AW = $clog2(MEM_DEPTH);

    logic               i_load_en;
    logic [AW-1:0]      i_load_addr;
    logic [NB_INST-1:0] i_load_data;
    logic               i_start;
    logic               i_stall;
    logic               i_flush;
    logic               i_jump;
    logic [NB_ADDR-1:0] i_jump_addr;
    logic [NB_ADDR-1:0] o_pc;
    logic [NB_INST-1:0] o_instruction;
    logic               o_valid;
    logic               o_running;
    logic               o_halted;
    fetch_state_t       o_state;

    modport master (
        output i_load_en, i_load_addr, i_load_data, i_start,
        output i_stall, i_flush, i_jump, i_jump_addr,
        input  o_pc, o_instruction, o_valid, o_running, o_halted, o_state
    );

    modport slave (
        input  i_load_en, i_load_addr, i_load_data, i_start,
        input  i_stall, i_flush, i_jump, i_jump_addr,
        output o_pc, o_instruction, o_valid, o_running, o_halted, o_state
    );

endinterface

// File: rtl/if_fetch_stage_inst_mem.sv
// Word-addressed instruction memory: one synchronous write port used to
// load the program, one combinational read port used by fetch.
// Contents are deliberately not reset so a program survives a reset.
module if_inst_mem #(
    parameter int NB_INST   = 32,
    parameter int MEM_DEPTH = 64,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [NB_INST-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output logic [NB_INST-1:0] o_rdata
);

    logic [NB_INST-1:0] mem [MEM_DEPTH];

    // Program load write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, IDLE/RUN/HALT sequencing and the registered
// IF/ID latch (PC+4, instruction, valid) that feeds decode.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int                  NB_ADDR   = 32,
    parameter int                  NB_INST   = 32,
    parameter int                  MEM_DEPTH = 64,
    parameter logic [NB_INST-1:0]  HALT_WORD = NB_INST'(HALT_WORD_DEFAULT)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    if_fetch_stage_if.slave     bus
);

    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [NB_ADDR-1:0] PC_STEP   = NB_ADDR'(PC_INC);
    localparam logic [NB_ADDR-1:0] PC_LIMIT  = NB_ADDR'(MEM_DEPTH * 4);
    localparam logic [NB_ADDR-1:0] ALIGN_MSK = ~NB_ADDR'(3);
    localparam logic [NB_INST-1:0] NOP       = NB_INST'(NOP_WORD);

    fetch_state_t       state_q, state_d;
    logic [NB_ADDR-1:0] pc_q, pc_d;
    logic [NB_ADDR-1:0] lat_pc_q, lat_pc_d;
    logic [NB_INST-1:0] lat_inst_q, lat_inst_d;
    logic               lat_valid_q, lat_valid_d;

    logic               mem_we;
    logic [NB_INST-1:0] mem_rdata;
    logic               out_of_range;
    logic [NB_INST-1:0] fetch_word;
    logic               capture;

    // Loading is only honoured while idle; running or halted ignore it
    assign mem_we = (state_q == ST_IDLE) && bus.i_load_en;

    if_inst_mem #(
        .NB_INST   (NB_INST),
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (mem_we),
        .i_waddr (bus.i_load_addr),
        .i_wdata (bus.i_load_data),
        .i_raddr (pc_q[AW+1:2]),
        .o_rdata (mem_rdata)
    );

    // A PC past the end of memory (including wrap) reads as the halt word
    assign out_of_range = (pc_q >= PC_LIMIT);
    assign fetch_word   = out_of_range ? HALT_WORD : mem_rdata;
    // The latch takes a fetched word only when neither flushed nor stalled
    assign capture      = !bus.i_stall && !bus.i_flush;

    // State, PC and IF/ID latch registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            lat_pc_q    <= '0;
            lat_inst_q  <= NOP;
            lat_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            lat_pc_q    <= lat_pc_d;
            lat_inst_q  <= lat_inst_d;
            lat_valid_q <= lat_valid_d;
        end
    end

    // Next state, next PC and next latch contents
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        lat_pc_d    = lat_pc_q;
        lat_inst_d  = lat_inst_q;
        lat_valid_d = lat_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start && !bus.i_load_en) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end
            end

            ST_RUN: begin
                if (capture && (fetch_word == HALT_WORD)) begin
                    // Halt word reached: bubble out, freeze the PC for good
                    state_d     = ST_HALT;
                    lat_inst_d  = NOP;
                    lat_valid_d = 1'b0;
                end else begin
                    if (capture) begin
                        lat_pc_d    = pc_q + PC_STEP;
                        lat_inst_d  = fetch_word;
                        lat_valid_d = 1'b1;
                    end
                    if (bus.i_flush) begin
                        lat_inst_d  = NOP;
                        lat_valid_d = 1'b0;
                    end
                    // A jump redirects the PC even while stalled
                    if (bus.i_jump) begin
                        pc_d = bus.i_jump_addr & ALIGN_MSK;
                    end else if (!bus.i_stall) begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.o_pc          = lat_pc_q;
    assign bus.o_instruction = lat_inst_q;
    assign bus.o_valid       = lat_valid_q;
    assign bus.o_running     = (state_q == ST_RUN);
    assign bus.o_halted      = (state_q == ST_HALT);
    assign bus.o_state       = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a cycle-level reference model predicts the
// IF/ID latch and status after each edge, and a monitor compares.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    localparam int NB_ADDR   = 32;
    localparam int NB_INST   = 32;
    localparam int MEM_DEPTH = 64;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk;
    logic rst_n;

    if_fetch_stage_if #(
        .NB_ADDR   (NB_ADDR),
        .NB_INST   (NB_INST),
        .MEM_DEPTH (MEM_DEPTH)
    ) bus ();

    if_fetch_stage #(
        .NB_ADDR   (NB_ADDR),
        .NB_INST   (NB_INST),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [66:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_mem [MEM_DEPTH];
    logic [31:0] m_pc;
    int          m_mode;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_valid;

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got pc=%h inst=%h v=%b run=%b halt=%b, want pc=%h inst=%h v=%b run=%b halt=%b",
                      name, act[66:35], act[34:3], act[2], act[1], act[0],
                      exp[66:35], exp[34:3], exp[2], exp[1], exp[0]);
    endtask

    // One clock of the fetch stage described as program semantics: the word
    // at byte address PC (anything past the memory reads as the halt word)
    // moves into the latch unless stalled or flushed.
    task automatic model_step(input bit ld, input logic [5:0] la, input logic [31:0] lw,
                              input bit st, input bit stl, input bit fl, input bit jp,
                              input logic [31:0] ja);
        logic [31:0] word;
        bit take;
        if (m_mode == M_IDLE) begin
            if (ld) m_mem[la] = lw;
            else if (st) begin
                m_mode = M_RUN;
                m_pc   = 0;
            end
        end else if (m_mode == M_RUN) begin
            word = (m_pc >= MEM_DEPTH * 4) ? HALT : m_mem[m_pc / 4];
            take = !stl && !fl;
            if (take && word == HALT) begin
                m_mode  = M_HALT;
                e_inst  = 0;
                e_valid = 0;
            end else begin
                if (take) begin
                    e_pc    = m_pc + 4;
                    e_inst  = word;
                    e_valid = 1;
                end
                if (fl) begin
                    e_inst  = 0;
                    e_valid = 0;
                end
                if (jp) m_pc = (ja / 4) * 4;
                else if (!stl) m_pc = m_pc + 4;
            end
        end
    endtask

    function automatic logic [66:0] model_outputs();
        return {e_pc, e_inst, e_valid, (m_mode == M_RUN), (m_mode == M_HALT)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input bit ld, input logic [5:0] la, input logic [31:0] lw,
                         input bit st, input bit stl, input bit fl, input bit jp,
                         input logic [31:0] ja);
        @(negedge clk);
        bus.i_load_en   = ld;
        bus.i_load_addr = la;
        bus.i_load_data = lw;
        bus.i_start     = st;
        bus.i_stall     = stl;
        bus.i_flush     = fl;
        bus.i_jump      = jp;
        bus.i_jump_addr = ja;
        model_step(ld, la, lw, st, stl, fl, jp, ja);
        exp_q.push_back(model_outputs());
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset lands between clock edges; the outputs must clear at once.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        bus.i_load_en = 0; bus.i_start = 0; bus.i_stall = 0;
        bus.i_flush   = 0; bus.i_jump  = 0;
        rst_n = 1'b0;
        #1;
        m_mode = M_IDLE; m_pc = 0; e_pc = 0; e_inst = 0; e_valid = 0;
        check({tag, "_outputs"},
              {bus.o_pc, bus.o_instruction, bus.o_valid, bus.o_running, bus.o_halted},
              model_outputs());
        check({tag, "_state"}, 67'(bus.o_state), 67'(ST_IDLE));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [66:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("latch", {bus.o_pc, bus.o_instruction, bus.o_valid,
                                bus.o_running, bus.o_halted}, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] w;
        logic [31:0] ja;
        bit stl, fl, jp, ld;

        rst_n = 1'b1;
        bus.i_load_en = 0; bus.i_load_addr = 0; bus.i_load_data = 0;
        bus.i_start   = 0; bus.i_stall     = 0; bus.i_flush     = 0;
        bus.i_jump    = 0; bus.i_jump_addr = 0;
        m_mode = M_IDLE; m_pc = 0; e_pc = 0; e_inst = 0; e_valid = 0;
        for (int i = 0; i < MEM_DEPTH; i++) m_mem[i] = 0;

        async_reset("reset");

        // Program: two real words then the halt word; the rest random
        drive(1, 0, 32'h2001_0005, 0, 0, 0, 0, 0);
        drive(1, 1, 32'h2002_0007, 0, 0, 0, 0, 0);
        drive(1, 2, HALT,          0, 0, 0, 0, 0);
        for (int i = 3; i < MEM_DEPTH; i++) drive(1, 6'(i), $urandom() & 32'h7FFF_FFFF, 0, 0, 0, 0, 0);
        // Start together with a load: the write wins and the stage stays idle
        drive(1, 3, 32'h0BAD_0003, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        idle_cycles(6);

        // Back to idle, replace the halt word, run the control scenarios
        async_reset("halt_reset");
        drive(1, 2, 32'h2003_0009, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        idle_cycles(1);                                  // latch (4, mem[0]), PC=4
        drive(0, 0, 0, 0, 0, 1, 1, 32'h10);              // jump+flush -> bubble
        idle_cycles(2);                                  // (0x14, mem[4]), (0x18, mem[5])
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0, 0, 0);
        idle_cycles(2);                                  // resumes at mem[6]
        drive(0, 0, 0, 0, 1, 0, 1, 32'h20);              // jump under stall
        idle_cycles(2);                                  // (0x24, mem[8])
        drive(0, 0, 0, 0, 0, 0, 1, 32'h2B);              // misaligned target -> 0x28
        idle_cycles(2);

        // Random fetch control; loads are sprinkled in and must be ignored
        for (int i = 0; i < 300; i++) begin
            stl = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            jp  = ($urandom_range(0, 11) == 0);
            ld  = ($urandom_range(0, 9) == 0);
            ja  = 32'($urandom_range(0, 32'hDF));
            if (m_pc >= 32'hE0) jp = 1;                  // keep inside memory
            drive(ld, 6'($urandom_range(0, MEM_DEPTH - 1)), $urandom(), 0, stl, fl, jp, ja);
        end

        // Reset mid-run; program is retained
        async_reset("run_reset");
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        idle_cycles(4);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h100);             // out-of-range target
        idle_cycles(3);
        drive(1, 0, 32'h1234_5678, 0, 0, 0, 0, 0);       // ignored while halted
        drive(0, 0, 0, 1, 0, 0, 1, 32'h0);               // ignored while halted
        idle_cycles(2);

        async_reset("final_reset");
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        idle_cycles(3);

        // Drain: every expectation must have been consumed
        @(posedge clk);
        #2;
        check("drain", 67'(exp_q.size()), 67'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
